// File: rtl/rr_pkg.sv
// Shared ROB sizing, recovery FSM states and modular index helpers.
// Indices wrap at ROB_DEPTH, which need not be a power of two.
package rr_pkg;

    localparam int INSTR_COUNT = 2;
    localparam int ROB_DEPTH   = 96;
    localparam int ROB_W       = $clog2(ROB_DEPTH);
    localparam int CNT_W       = $clog2(ROB_DEPTH + 1);

    typedef logic [ROB_W-1:0] rob_id_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN
    } rec_state_e;

    // (idx + n) mod ROB_DEPTH, valid for idx < ROB_DEPTH and n <= ROB_DEPTH.
    function automatic rob_id_t rob_inc(input rob_id_t idx, input rob_id_t n);
        logic [ROB_W:0] sum;
        sum = {1'b0, idx} + {1'b0, n};
        if (sum >= (ROB_W+1)'(ROB_DEPTH)) begin
            sum = sum - (ROB_W+1)'(ROB_DEPTH);
        end
        return sum[ROB_W-1:0];
    endfunction

    // (a - b) mod ROB_DEPTH: distance walking forward from b to a.
    function automatic rob_id_t rob_sub(input rob_id_t a, input rob_id_t b);
        logic [ROB_W:0] diff;
        if (a >= b) begin
            diff = {1'b0, a} - {1'b0, b};
        end else begin
            diff = {1'b0, a} + (ROB_W+1)'(ROB_DEPTH) - {1'b0, b};
        end
        return diff[ROB_W-1:0];
    endfunction

endpackage

// File: rtl/rr_rob_status.sv
// Per-entry valid/done bits: alloc sets valid, writeback sets done, commit and flush clear valid.
// All updates land on the next clock edge; no backpressure, every request is applied.
module rr_rob_status
    import rr_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               alloc_en,
    input  logic [INSTR_COUNT-1:0][ROB_W-1:0]  alloc_idx,
    input  logic [INSTR_COUNT-1:0]             wb_en,
    input  logic [INSTR_COUNT-1:0][ROB_W-1:0]  wb_idx,
    input  logic [INSTR_COUNT-1:0]             clr_en,
    input  logic [INSTR_COUNT-1:0][ROB_W-1:0]  clr_idx,
    input  logic                               flush_en,
    input  logic [ROB_W-1:0]                   flush_lo,
    input  logic [ROB_W-1:0]                   flush_span,
    output logic [ROB_DEPTH-1:0]               valid,
    output logic [ROB_DEPTH-1:0]               done
);

    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        // Squash flush_span entries starting at flush_lo, walking forward with wrap.
        if (flush_en) begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                if (rob_sub(ROB_W'(j), flush_lo) < flush_span) begin
                    valid_d[j] = 1'b0;
                end
            end
        end
        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (clr_en[i]) begin
                valid_d[clr_idx[i]] = 1'b0;
            end
            if (wb_en[i] && (wb_idx[i] < ROB_W'(ROB_DEPTH)) && valid_q[wb_idx[i]]) begin
                done_d[wb_idx[i]] = 1'b1;
            end
        end
        if (alloc_en) begin
            for (int i = 0; i < INSTR_COUNT; i++) begin
                valid_d[alloc_idx[i]] = 1'b1;
                done_d[alloc_idx[i]]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: rtl/rr_rob_tracker.sv
// In-order ROB tracker: hands out ids, records writebacks, retires in order, drives rename recovery.
// Commit is registered (2 cycles from writeback at head); alloc_ready drops when full or recovering.
module rr_rob_tracker
    import rr_pkg::*;
#(
    parameter int REC_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               alloc_ready,
    input  logic                               alloc_en,
    output logic [INSTR_COUNT-1:0][ROB_W-1:0]  alloc_rob_id,
    input  logic [INSTR_COUNT-1:0]             wb_en,
    input  logic [INSTR_COUNT-1:0][ROB_W-1:0]  wb_rob_id,
    input  logic                               flush_en,
    input  logic [ROB_W-1:0]                   flush_rob_id,
    output logic [INSTR_COUNT-1:0]             commit_en,
    output logic [INSTR_COUNT-1:0][ROB_W-1:0]  commit_rob_id,
    output logic                               rec_en,
    output logic [ROB_W-1:0]                   rec_rob_id,
    output logic                               rec_busy
);

    localparam int DRN_W = $clog2(REC_CYCLES + 1);

    logic [ROB_DEPTH-1:0]               valid, done;
    rob_id_t                            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                   count_q, count_d, n_ret;
    rec_state_e                         state_q, state_d;
    logic [DRN_W-1:0]                   drain_q, drain_d;
    logic [INSTR_COUNT-1:0]             commit_en_q, commit_en_d, retire;
    logic [INSTR_COUNT-1:0][ROB_W-1:0]  commit_rob_id_q, commit_rob_id_d, ret_idx;
    logic                               rec_en_q, rec_en_d, rec_busy_q, rec_busy_d;
    rob_id_t                            rec_rob_id_q, rec_rob_id_d;
    logic                               flush_ok, alloc_fire, prev_ret;
    rob_id_t                            flush_keep, flush_lo, flush_span;

    always_comb begin
        flush_ok = (state_q == IDLE) && flush_en
                   && (flush_rob_id < ROB_W'(ROB_DEPTH)) && valid[flush_rob_id];
        flush_keep = rob_sub(flush_rob_id, head_q);
        flush_lo   = rob_inc(flush_rob_id, ROB_W'(1));
        flush_span = rob_sub(tail_q, flush_lo);

        alloc_ready = (state_q == IDLE) && (count_q <= CNT_W'(ROB_DEPTH - INSTR_COUNT));
        alloc_fire  = alloc_en && alloc_ready && !flush_ok;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            alloc_rob_id[i] = rob_inc(tail_q, ROB_W'(i));
        end

        // Squashed entries beyond the flush point must not retire on the flush edge.
        n_ret    = '0;
        prev_ret = 1'b1;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            ret_idx[i] = rob_inc(head_q, ROB_W'(i));
            retire[i]  = prev_ret && valid[ret_idx[i]] && done[ret_idx[i]]
                         && (!flush_ok || (ROB_W'(i) <= flush_keep));
            prev_ret   = retire[i];
            n_ret      = n_ret + CNT_W'(retire[i]);
            commit_rob_id_d[i] = retire[i] ? ret_idx[i] : commit_rob_id_q[i];
        end
        commit_en_d = retire;

        head_d  = rob_inc(head_q, ROB_W'(n_ret));
        tail_d  = tail_q;
        count_d = count_q - n_ret;
        if (flush_ok) begin
            tail_d  = flush_lo;
            count_d = CNT_W'(flush_keep) + CNT_W'(1) - n_ret;
        end else if (alloc_fire) begin
            tail_d  = rob_inc(tail_q, ROB_W'(INSTR_COUNT));
            count_d = count_q - n_ret + CNT_W'(INSTR_COUNT);
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        rec_en_d     = 1'b0;
        rec_busy_d   = 1'b0;
        rec_rob_id_d = rec_rob_id_q;
        case (state_q)
            IDLE: begin
                if (flush_ok) begin
                    state_d      = FLUSH;
                    rec_en_d     = 1'b1;
                    rec_busy_d   = 1'b1;
                    rec_rob_id_d = flush_rob_id;
                end
            end
            FLUSH: begin
                state_d    = DRAIN;
                drain_d    = DRN_W'(REC_CYCLES);
                rec_busy_d = 1'b1;
            end
            DRAIN: begin
                drain_d    = drain_q - DRN_W'(1);
                rec_busy_d = (drain_d != '0);
                if (drain_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= IDLE;
            drain_q         <= '0;
            commit_en_q     <= '0;
            commit_rob_id_q <= '0;
            rec_en_q        <= 1'b0;
            rec_rob_id_q    <= '0;
            rec_busy_q      <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            state_q         <= state_d;
            drain_q         <= drain_d;
            commit_en_q     <= commit_en_d;
            commit_rob_id_q <= commit_rob_id_d;
            rec_en_q        <= rec_en_d;
            rec_rob_id_q    <= rec_rob_id_d;
            rec_busy_q      <= rec_busy_d;
        end
    end

    rr_rob_status u_status (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (alloc_fire),
        .alloc_idx  (alloc_rob_id),
        .wb_en      (wb_en),
        .wb_idx     (wb_rob_id),
        .clr_en     (retire),
        .clr_idx    (ret_idx),
        .flush_en   (flush_ok),
        .flush_lo   (flush_lo),
        .flush_span (flush_span),
        .valid      (valid),
        .done       (done)
    );

    assign commit_en     = commit_en_q;
    assign commit_rob_id = commit_rob_id_q;
    assign rec_en        = rec_en_q;
    assign rec_rob_id    = rec_rob_id_q;
    assign rec_busy      = rec_busy_q;

endmodule

// File: tb/tb_rr_rob_tracker.sv
// Randomised and directed bench for rr_rob_tracker against a queue-based ROB model.
module tb_rr_rob_tracker;

    localparam int IC  = 2;
    localparam int D   = 96;
    localparam int W   = 7;
    localparam int REC = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 alloc_ready, alloc_en;
    logic [IC-1:0][W-1:0] alloc_rob_id;
    logic [IC-1:0]        wb_en;
    logic [IC-1:0][W-1:0] wb_rob_id;
    logic                 flush_en;
    logic [W-1:0]         flush_rob_id;
    logic [IC-1:0]        commit_en;
    logic [IC-1:0][W-1:0] commit_rob_id;
    logic                 rec_en, rec_busy;
    logic [W-1:0]         rec_rob_id;

    always #5 clk = ~clk;

    rr_rob_tracker #(.REC_CYCLES(REC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_ready   (alloc_ready),
        .alloc_en      (alloc_en),
        .alloc_rob_id  (alloc_rob_id),
        .wb_en         (wb_en),
        .wb_rob_id     (wb_rob_id),
        .flush_en      (flush_en),
        .flush_rob_id  (flush_rob_id),
        .commit_en     (commit_en),
        .commit_rob_id (commit_rob_id),
        .rec_en        (rec_en),
        .rec_rob_id    (rec_rob_id),
        .rec_busy      (rec_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: live entries as an ordered queue of ids (oldest first).
    int                   mq[$];
    bit                   mdone[D];
    int                   mtail;
    int                   rec_rem;
    logic [IC-1:0]        exp_cen;
    logic [IC-1:0][W-1:0] exp_cid;
    logic                 exp_ren, exp_busy;
    logic [W-1:0]         exp_rid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qpos(input int id);
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k] == id) return k;
        end
        return -1;
    endfunction

    function automatic bit model_ready();
        return (rec_rem == 0) && (mq.size() <= D - IC);
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (mdone[i]) mdone[i] = 1'b0;
        mtail    = 0;
        rec_rem  = 0;
        exp_cen  = '0;
        exp_cid  = '0;
        exp_ren  = 1'b0;
        exp_busy = 1'b0;
        exp_rid  = '0;
    endtask

    task automatic model_edge();
        int  fpos, k;
        bit  fok, rdy;
        bit  wb_ok[IC];
        rdy  = model_ready();
        fpos = qpos(int'(flush_rob_id));
        fok  = (rec_rem == 0) && flush_en && (fpos >= 0);
        k = 0;
        while (k < IC && k < mq.size() && mdone[mq[k]] && (!fok || k <= fpos)) k++;
        exp_cen = '0;
        for (int i = 0; i < k; i++) begin
            exp_cen[i] = 1'b1;
            exp_cid[i] = W'(mq[i]);
        end
        for (int p = 0; p < IC; p++) wb_ok[p] = wb_en[p] && (qpos(int'(wb_rob_id[p])) >= 0);
        for (int p = 0; p < IC; p++) if (wb_ok[p]) mdone[wb_rob_id[p]] = 1'b1;
        if (fok) begin
            while (mq.size() > fpos + 1) void'(mq.pop_back());
            mtail = (int'(flush_rob_id) + 1) % D;
        end else if (alloc_en && rdy) begin
            for (int i = 0; i < IC; i++) begin
                mq.push_back(mtail);
                mdone[mtail] = 1'b0;
                mtail = (mtail + 1) % D;
            end
        end
        for (int i = 0; i < k; i++) void'(mq.pop_front());
        exp_ren = 1'b0;
        if (rec_rem > 0) begin
            rec_rem--;
        end else if (fok) begin
            rec_rem = 1 + REC;
            exp_ren = 1'b1;
            exp_rid = flush_rob_id;
        end
        exp_busy = (rec_rem > 0);
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic cycle(input logic a_en, input logic [IC-1:0] w_en, input int w0, input int w1,
                         input logic f_en, input int fid);
        alloc_en     = a_en;
        wb_en        = w_en;
        wb_rob_id[0] = W'(w0);
        wb_rob_id[1] = W'(w1);
        flush_en     = f_en;
        flush_rob_id = W'(fid);
        #1;
        check_eq("alloc_ready", alloc_ready, model_ready());
        for (int i = 0; i < IC; i++) check_eq("alloc_rob_id", alloc_rob_id[i], (mtail + i) % D);
        model_edge();
        @(posedge clk);
        #1;
        check_eq("commit_en", commit_en, exp_cen);
        for (int i = 0; i < IC; i++) if (exp_cen[i]) check_eq("commit_rob_id", commit_rob_id[i], exp_cid[i]);
        check_eq("rec_en", rec_en, exp_ren);
        check_eq("rec_rob_id", rec_rob_id, exp_rid);
        check_eq("rec_busy", rec_busy, exp_busy);
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        logic [IC-1:0][W-1:0] ids0;
        ids0[0] = W'(0);
        ids0[1] = W'(1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_commit_en", commit_en, 0);
        check_eq("rst_commit_id", commit_rob_id, 0);
        check_eq("rst_rec_en", rec_en, 0);
        check_eq("rst_rec_id", rec_rob_id, 0);
        check_eq("rst_rec_busy", rec_busy, 0);
        check_eq("rst_alloc_ids", alloc_rob_id, ids0);
        model_reset();
        alloc_en = 1'b0; wb_en = '0; flush_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    function automatic int pick_id();
        if (mq.size() > 0 && $urandom_range(9, 0) < 8) return mq[$urandom_range(mq.size() - 1, 0)];
        return int'($urandom_range(127, 0));
    endfunction

    initial begin
        int bc;
        logic [IC-1:0][W-1:0] ids;
        rst_n = 1'b0;
        alloc_en = 1'b0; wb_en = '0; wb_rob_id = '0; flush_en = 1'b0; flush_rob_id = '0;
        model_reset();
        @(posedge clk);
        do_reset();

        // In-order retire with out-of-order writeback.
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        cycle(1'b0, 2'b01, 1, 0, 1'b0, 0);
        idle(); idle();
        check_eq("no_commit_before_wb0", commit_en, 0);
        cycle(1'b0, 2'b01, 0, 0, 1'b0, 0);
        idle();
        check_eq("commit_pair", commit_en, 2'b11);
        check_eq("commit_ids01", commit_rob_id, {7'd1, 7'd0});
        cycle(1'b0, 2'b01, 3, 0, 1'b0, 0);
        idle(); idle();
        check_eq("no_commit_before_wb2", commit_en, 0);
        cycle(1'b0, 2'b01, 2, 0, 1'b0, 0);
        idle();

        // Fill to full, crossing the wrap at 95 -> 0.
        for (int t = 0; t < 60 && model_ready(); t++) begin
            if (mtail == 94) begin
                ids[0] = W'(94); ids[1] = W'(95);
                check_eq("wrap_ids", alloc_rob_id, ids);
            end
            cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        end
        check_eq("full_ready", alloc_ready, 0);
        cycle(1'b0, 2'b11, mq[0], mq[1], 1'b0, 0);
        idle();
        check_eq("ready_after_commit", alloc_ready, 1);
        for (int t = 0; t < 300 && mq.size() > 0; t++) begin
            cycle(1'b0, 2'b11, mq[0], (mq.size() > 1) ? mq[1] : mq[0], 1'b0, 0);
        end

        // Reset with traffic in flight, then flush scenarios from a clean ROB.
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        do_reset();
        for (int t = 0; t < 4; t++) cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        cycle(1'b0, 2'b00, 0, 0, 1'b1, 3);
        check_eq("flush_rec_en", rec_en, 1);
        check_eq("flush_rec_id", rec_rob_id, 3);
        bc = 1;
        cycle(1'b0, 2'b01, 5, 5, 1'b1, 2);
        if (rec_busy) bc++;
        for (int t = 0; t < 10 && rec_busy; t++) begin
            idle();
            if (rec_busy) bc++;
        end
        check_eq("rec_busy_len", bc, 1 + REC);
        cycle(1'b0, 2'b01, 5, 5, 1'b0, 0);
        ids[0] = W'(4); ids[1] = W'(5);
        check_eq("post_flush_ids", alloc_rob_id, ids);
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);

        cycle(1'b1, 2'b00, 0, 0, 1'b1, 4);
        for (int t = 0; t < 10 && !model_ready(); t++) idle();
        check_eq("flush_alloc_tail", alloc_rob_id[0], 5);
        cycle(1'b0, 2'b00, 0, 0, 1'b1, 60);
        check_eq("flush_invalid", rec_en, 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            logic         a, f;
            logic [IC-1:0] we;
            int           w0, w1, fid;
            a   = model_ready() && ($urandom_range(2, 0) != 0);
            we  = IC'($urandom_range(3, 0));
            w0  = pick_id();
            w1  = pick_id();
            f   = ($urandom_range(39, 0) == 0);
            fid = pick_id();
            cycle(a, we, w0, w1, f, fid);
            if ($urandom_range(799, 0) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
